// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the single-master initiator.
// Also provides the alignment helper used by the optional request alignment check.
package ahb_pkg;

    localparam int AHB_ADDR_W = 32;
    localparam int AHB_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_e;

    typedef enum logic [2:0] {
        BYTE  = 3'd0,
        HALF  = 3'd1,
        WORD  = 3'd2,
        DWORD = 3'd3
    } hsize_e;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } hresp_e;

    // Data access, privileged.
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    typedef struct packed {
        logic [AHB_ADDR_W-1:0] addr;
        logic                  write;
        logic [2:0]            size;
        logic [AHB_DATA_W-1:0] wdata;
    } ahb_req_t;

    function automatic logic is_misaligned(input logic [AHB_ADDR_W-1:0] addr,
                                           input logic [2:0]            size);
        case (size)
            3'd0:    is_misaligned = 1'b0;
            3'd1:    is_misaligned = addr[0];
            3'd2:    is_misaligned = |addr[1:0];
            3'd3:    is_misaligned = |addr[2:0];
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-master initiator: valid/ready requests -> pipelined SINGLE/NONSEQ transfers.
// Optional macro AHB_MASTER_ALIGN_CHECK_EN turns misaligned requests into local error responses.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic              i_req_write,
    input  logic [2:0]        i_req_size,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [ADDR_W-1:0] o_haddr,
    output logic [2:0]        o_hburst,
    output logic [2:0]        o_hsize,
    output logic [3:0]        o_hprot,
    output logic [1:0]        o_htrans,
    output logic              o_hwrite,
    output logic [DATA_W-1:0] o_hwdata,
    input  logic [DATA_W-1:0] i_hrdata,
    input  logic              i_hresp,
    input  logic              i_hready
);

    typedef enum logic {
        RUN  = 1'b0,
        ERR2 = 1'b1
    } state_e;

    state_e            state_q;
    ahb_req_t          a_q;
    logic              a_vld_q;
    logic              a_lerr_q;
    logic              d_vld_q;
    logic              d_write_q;
    logic              d_lerr_q;
    logic [DATA_W-1:0] hwdata_q;
    logic              rsp_vld_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    ahb_req_t          req_d;
    logic              req_lerr_d;
    logic              req_fire;

    assign o_req_ready = (!a_vld_q || i_hready) && (state_q == RUN) && i_rst_n;
    assign req_fire    = i_req_valid && o_req_ready;

    assign req_d.addr  = AHB_ADDR_W'(i_req_addr);
    assign req_d.write = i_req_write;
    assign req_d.size  = i_req_size;
    assign req_d.wdata = AHB_DATA_W'(i_req_wdata);

`ifdef AHB_MASTER_ALIGN_CHECK_EN
    assign req_lerr_d = is_misaligned(req_d.addr, req_d.size);
`else
    assign req_lerr_d = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= RUN;
            a_q         <= '0;
            a_vld_q     <= 1'b0;
            a_lerr_q    <= 1'b0;
            d_vld_q     <= 1'b0;
            d_write_q   <= 1'b0;
            d_lerr_q    <= 1'b0;
            hwdata_q    <= '0;
            rsp_vld_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_vld_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;

            // A accepts a new request whenever ready; it empties only as it advances into D.
            if (req_fire) begin
                a_q      <= req_d;
                a_vld_q  <= 1'b1;
                a_lerr_q <= req_lerr_d;
            end else if (state_q == RUN && i_hready) begin
                a_q      <= '0;
                a_vld_q  <= 1'b0;
                a_lerr_q <= 1'b0;
            end

            case (state_q)
                RUN: begin
                    if (i_hready) begin
                        if (d_vld_q) begin
                            rsp_vld_q   <= 1'b1;
                            rsp_err_q   <= i_hresp | d_lerr_q;
                            rsp_rdata_q <= (d_write_q || i_hresp || d_lerr_q) ? '0 : i_hrdata;
                        end
                        d_vld_q   <= a_vld_q;
                        d_write_q <= a_q.write;
                        d_lerr_q  <= a_lerr_q;
                        hwdata_q  <= DATA_W'(a_q.wdata);
                    end else if (d_vld_q && i_hresp && !d_lerr_q) begin
                        state_q <= ERR2;
                    end
                end
                ERR2: begin
                    // Second error cycle: the waiting address phase was cancelled and is re-issued.
                    if (i_hready) begin
                        rsp_vld_q <= 1'b1;
                        rsp_err_q <= 1'b1;
                        d_vld_q   <= 1'b0;
                        state_q   <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign o_htrans    = (a_vld_q && !a_lerr_q && state_q == RUN) ? NONSEQ : IDLE;
    assign o_haddr     = ADDR_W'(a_q.addr);
    assign o_hsize     = a_q.size;
    assign o_hwrite    = a_q.write;
    assign o_hburst    = SINGLE;
    assign o_hprot     = HPROT_DEFAULT;
    assign o_hwdata    = hwdata_q;
    assign o_rsp_valid = rsp_vld_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master; the bench plays the AHB slave cycle by cycle.
module tb_ahb_lite_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [2:0]  req_size;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] haddr;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [63:0] hwdata;
    logic [63:0] hrdata;
    logic        hresp;
    logic        hready;

    int n_chk  = 0;
    int n_pass = 0;

    ahb_lite_master #(.ADDR_W(32), .DATA_W(64)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_addr  (req_addr),
        .i_req_write (req_write),
        .i_req_size  (req_size),
        .i_req_wdata (req_wdata),
        .o_rsp_valid (rsp_valid),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_err   (rsp_err),
        .o_haddr     (haddr),
        .o_hburst    (hburst),
        .o_hsize     (hsize),
        .o_hprot     (hprot),
        .o_htrans    (htrans),
        .o_hwrite    (hwrite),
        .o_hwdata    (hwdata),
        .i_hrdata    (hrdata),
        .i_hresp     (hresp),
        .i_hready    (hready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setreq(input logic v, input logic w, input logic [31:0] a,
                          input logic [2:0] s, input logic [63:0] d);
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_size  = s;
        req_wdata = d;
    endtask

    initial begin
        rst_n  = 1'b0;
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = '0;
        setreq(1'b1, 1'b1, 32'h44, 3'd3, 64'h1234);

        // Reset state
        #22;
        chk("rst_htrans", htrans, 0);
        chk("rst_haddr", haddr, 0);
        chk("rst_hwdata", hwdata, 0);
        chk("rst_hwrite", hwrite, 0);
        chk("rst_hsize", hsize, 0);
        chk("rst_hburst", hburst, 0);
        chk("rst_hprot", hprot, 4'b0011);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_req_ready", req_ready, 0);
        #1 rst_n = 1'b1;
        req_valid = 1'b0;
        tick();

        // Write 0xDEADBEEF to 0x10 then read it back
        setreq(1'b1, 1'b1, 32'h10, 3'd3, 64'hDEADBEEF);
        #1 chk("wr_ready", req_ready, 1);
        tick();
        chk("wr_htrans", htrans, 2);
        chk("wr_haddr", haddr, 32'h10);
        chk("wr_hwrite", hwrite, 1);
        chk("wr_hsize", hsize, 3);
        setreq(1'b1, 1'b0, 32'h10, 3'd3, 64'h0);
        hrdata = 64'hDEADBEEF;
        #1 chk("rd_ready", req_ready, 1);
        tick();
        chk("rd_htrans", htrans, 2);
        chk("rd_hwrite", hwrite, 0);
        chk("wr_hwdata", hwdata, 64'hDEADBEEF);
        chk("wr_rsp_early", rsp_valid, 0);
        req_valid = 1'b0;
        tick();
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_err", rsp_err, 0);
        chk("wr_rsp_rdata", rsp_rdata, 0);
        chk("wr_idle", htrans, 0);
        tick();
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_err", rsp_err, 0);
        chk("rd_rsp_rdata", rsp_rdata, 64'hDEADBEEF);
        tick();
        chk("rd_rsp_done", rsp_valid, 0);

        // Eight back-to-back reads
        for (int k = 0; k < 10; k++) begin
            if (k < 8) setreq(1'b1, 1'b0, 32'(4 * k), 3'd2, 64'h0);
            else req_valid = 1'b0;
            hrdata = (k >= 2) ? 64'(64'hA000 + k - 2) : 64'h0;
            #1;
            if (k < 8) chk("b2b_ready", req_ready, 1);
            tick();
            if (k < 8) begin
                chk("b2b_htrans", htrans, 2);
                chk("b2b_haddr", haddr, 32'(4 * k));
            end else begin
                chk("b2b_idle", htrans, 0);
            end
            if (k >= 2) begin
                chk("b2b_rsp_valid", rsp_valid, 1);
                chk("b2b_rsp_rdata", rsp_rdata, 64'(64'hA000 + k - 2));
            end else begin
                chk("b2b_rsp_none", rsp_valid, 0);
            end
        end
        tick();
        chk("b2b_rsp_end", rsp_valid, 0);

        // Three writes, 3 wait states on the second
        setreq(1'b1, 1'b1, 32'h100, 3'd3, 64'h1);
        tick();
        setreq(1'b1, 1'b1, 32'h108, 3'd3, 64'h2);
        tick();
        chk("ws_haddr1", haddr, 32'h108);
        setreq(1'b1, 1'b1, 32'h110, 3'd3, 64'h3);
        tick();
        chk("ws_rsp0", rsp_valid, 1);
        chk("ws_haddr", haddr, 32'h110);
        chk("ws_hwdata", hwdata, 64'h2);
        req_valid = 1'b0;
        hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("ws_ready_low", req_ready, 0);
            tick();
            chk("ws_haddr_hold", haddr, 32'h110);
            chk("ws_hwdata_hold", hwdata, 64'h2);
            chk("ws_htrans_hold", htrans, 2);
            chk("ws_rsp_none", rsp_valid, 0);
        end
        hready = 1'b1;
        #1 chk("ws_ready_back", req_ready, 1);
        tick();
        chk("ws_rsp1", rsp_valid, 1);
        chk("ws_rsp1_err", rsp_err, 0);
        chk("ws_hwdata3", hwdata, 64'h3);
        chk("ws_idle", htrans, 0);
        tick();
        chk("ws_rsp2", rsp_valid, 1);
        tick();
        chk("ws_rsp_end", rsp_valid, 0);

        // ERROR on read at 0x40 with 0x48 pending
        hrdata = 64'hBAD;
        setreq(1'b1, 1'b0, 32'h40, 3'd3, 64'h0);
        tick();
        setreq(1'b1, 1'b0, 32'h48, 3'd3, 64'h0);
        tick();
        chk("err_haddr", haddr, 32'h48);
        chk("err_htrans1", htrans, 2);
        req_valid = 1'b0;
        hready = 1'b0;
        hresp = 1'b1;
        #1 chk("err_ready1", req_ready, 0);
        tick();
        chk("err_htrans_idle", htrans, 0);
        chk("err_rsp_none", rsp_valid, 0);
        hready = 1'b1;
        #1 chk("err_ready2", req_ready, 0);
        tick();
        chk("err_rsp_valid", rsp_valid, 1);
        chk("err_rsp_err", rsp_err, 1);
        chk("err_rsp_rdata", rsp_rdata, 0);
        chk("err_reissue", htrans, 2);
        chk("err_reissue_addr", haddr, 32'h48);
        hresp = 1'b0;
        #1 chk("err_ready3", req_ready, 1);
        hrdata = 64'h48CAFE;
        tick();
        chk("err_idle2", htrans, 0);
        chk("err_rsp_gap", rsp_valid, 0);
        tick();
        chk("retry_rsp_valid", rsp_valid, 1);
        chk("retry_rsp_err", rsp_err, 0);
        chk("retry_rsp_rdata", rsp_rdata, 64'h48CAFE);
        tick();

`ifdef AHB_MASTER_ALIGN_CHECK_EN
        // Misaligned word request becomes a local error
        setreq(1'b1, 1'b0, 32'h06, 3'd2, 64'h0);
        tick();
        chk("al_no_nonseq", htrans, 0);
        setreq(1'b1, 1'b0, 32'h08, 3'd3, 64'h0);
        hrdata = 64'h5555;
        tick();
        chk("al_next_htrans", htrans, 2);
        chk("al_next_haddr", haddr, 32'h08);
        req_valid = 1'b0;
        tick();
        chk("al_rsp_valid", rsp_valid, 1);
        chk("al_rsp_err", rsp_err, 1);
        chk("al_rsp_rdata", rsp_rdata, 0);
        tick();
        chk("al_ok_valid", rsp_valid, 1);
        chk("al_ok_err", rsp_err, 0);
        chk("al_ok_rdata", rsp_rdata, 64'h5555);
        tick();
`endif

        // Reset asserted during a wait state
        setreq(1'b1, 1'b0, 32'h80, 3'd3, 64'h0);
        tick();
        setreq(1'b1, 1'b0, 32'h88, 3'd3, 64'h0);
        tick();
        req_valid = 1'b0;
        hready = 1'b0;
        tick();
        chk("mr_htrans_wait", htrans, 2);
        chk("mr_haddr_wait", haddr, 32'h88);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_htrans", htrans, 0);
        chk("mr_rsp_valid", rsp_valid, 0);
        chk("mr_haddr", haddr, 0);
        chk("mr_ready", req_ready, 0);
        #1 rst_n = 1'b1;
        hready = 1'b1;
        tick();
        chk("mr_no_rsp", rsp_valid, 0);
        setreq(1'b1, 1'b0, 32'h20, 3'd3, 64'h0);
        hrdata = 64'h2020;
        tick();
        chk("mr_htrans_new", htrans, 2);
        req_valid = 1'b0;
        tick();
        chk("mr_rsp_early", rsp_valid, 0);
        tick();
        chk("mr_rsp_valid", rsp_valid, 1);
        chk("mr_rsp_err", rsp_err, 0);
        chk("mr_rsp_rdata", rsp_rdata, 64'h2020);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
